// File: rtl/fir_lane.sv
// rtl/fir_lane.sv - one FIR lane: sample RAM, external coefficient RAM, MAC pipeline.
// FIR_LANE_SAT_EN selects saturating output instead of 16-bit wrap.
module fir_lane #(
  parameter int acw = 30,
  parameter int pcmaw = 8,
  parameter int mul_num = 2,
  localparam int paw = (mul_num == 2) ? pcmaw - 1 : pcmaw,
  localparam int pqw = (mul_num == 2) ? 32 : 16
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic                    pcm_in_wr,
  input  logic signed [15:0]      pcm_in,
  input  logic        [pcmaw-1:0] pcm_in_address,
  output logic signed [15:0]      pcm_out,
  input  logic        [pqw-1:0]   param_q,
  output logic        [paw-1:0]   param_addr,
  input  logic        [3:0]       pcm_out_shift,
  input  logic                    fir_start,
  input  logic        [11:0]      tap_len,
  output logic                    fir_done
);

  logic signed [15:0] mem [2**pcmaw];

  logic               busy, issuing, v1, v2;
  logic [pcmaw-1:0]   base, rd0;
  logic [11:0]        len, widx;
  logic [3:0]         sh;
  logic [12:0]        cnt;
  logic signed [15:0] samp0;
  logic signed [31:0] prod0, prod1;
  logic signed [acw-1:0] acc, shifted;
  logic signed [15:0] reduced;

  always_ff @(posedge clk1) begin
    if (pcm_in_wr) mem[pcm_in_address] <= pcm_in;
  end

  // Word widx covers taps widx*mul_num (and the next one when mul_num=2).
  assign rd0 = base - ((mul_num == 2) ? pcmaw'({widx, 1'b0}) : pcmaw'(widx));

  always_ff @(posedge clk1) begin
    if (issuing) samp0 <= mem[rd0];
    prod0 <= samp0 * $signed(param_q[15:0]);
  end

  generate
    if (mul_num == 2) begin : g_dual
      logic [pcmaw-1:0]   rd1;
      logic signed [15:0] samp1;
      assign rd1 = rd0 - pcmaw'(1);
      always_ff @(posedge clk1) begin
        if (issuing) samp1 <= mem[rd1];
        prod1 <= samp1 * $signed(param_q[pqw-1:16]);
      end
    end else begin : g_single
      assign prod1 = '0;
    end
  endgenerate

  assign shifted = acc >>> sh;

`ifdef FIR_LANE_SAT_EN
  localparam logic signed [acw-1:0] pos_lim = acw'(32767);
  localparam logic signed [acw-1:0] neg_lim = acw'(-32768);
  always_comb begin
    reduced = 16'(shifted);
    if (shifted > pos_lim)      reduced = 16'sh7fff;
    else if (shifted < neg_lim) reduced = 16'sh8000;
  end
`else
  assign reduced = 16'(shifted);
`endif

  // Pipeline: read sample+coef, multiply, accumulate; result lands at cnt == len+3.
  always_ff @(posedge clk1) begin
    if (rst) begin
      busy       <= 1'b0;
      issuing    <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      acc        <= '0;
      pcm_out    <= '0;
      fir_done   <= 1'b0;
      param_addr <= '0;
      cnt        <= '0;
      widx       <= '0;
      base       <= '0;
      len        <= '0;
      sh         <= '0;
    end else begin
      fir_done <= 1'b0;
      v1       <= issuing;
      v2       <= v1;
      if (v2) acc <= acc + acw'(prod0) + acw'(prod1);
      if (!busy) begin
        if (fir_start) begin
          busy       <= 1'b1;
          issuing    <= (tap_len != 12'd0);
          base       <= pcm_in_address;
          len        <= tap_len;
          sh         <= pcm_out_shift;
          widx       <= '0;
          cnt        <= '0;
          param_addr <= '0;
          acc        <= '0;
        end
      end else begin
        cnt <= cnt + 13'd1;
        if (issuing) begin
          widx <= widx + 12'd1;
          if (widx + 12'd1 == len) issuing <= 1'b0;
          else param_addr <= param_addr + paw'(1);
        end
        if (cnt == {1'b0, len} + 13'd3) begin
          busy     <= 1'b0;
          fir_done <= 1'b1;
          pcm_out  <= reduced;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_lane.sv
// tb/tb_fir_lane.sv - self-checking bench for fir_lane with a result scoreboard.
`timescale 1ns/1ps
module tb_fir_lane;
  localparam int ACW = 40;

  logic               clk1 = 1'b0;
  logic               rst = 1'b1;
  logic               pcm_in_wr = 1'b0;
  logic signed [15:0] pcm_in = '0;
  logic [7:0]         pcm_in_address = '0;
  logic signed [15:0] pcm_out;
  logic [31:0]        param_q = '0;
  logic [6:0]         param_addr;
  logic [3:0]         pcm_out_shift = '0;
  logic               fir_start = 1'b0;
  logic [11:0]        tap_len = '0;
  logic               fir_done;

  fir_lane #(.acw(ACW), .pcmaw(8), .mul_num(2)) dut (
    .clk1(clk1), .rst(rst), .pcm_in_wr(pcm_in_wr), .pcm_in(pcm_in),
    .pcm_in_address(pcm_in_address), .pcm_out(pcm_out), .param_q(param_q),
    .param_addr(param_addr), .pcm_out_shift(pcm_out_shift), .fir_start(fir_start),
    .tap_len(tap_len), .fir_done(fir_done)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] coef_mem [128];
  always @(posedge clk1) param_q <= coef_mem[param_addr];

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  typedef struct { logic signed [15:0] val; int cyc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic signed [15:0] smem [256];
  logic signed [15:0] last_out = '0;
  int tests = 0;
  int fails = 0;

  function automatic logic signed [15:0] model(input int base, input int len, input int sh);
    longint acc = 0;
    longint c, s;
    logic [31:0] w;
    for (int k = 0; k < len * 2; k++) begin
      w = coef_mem[k / 2];
      c = (k % 2 == 0) ? longint'($signed(w[15:0])) : longint'($signed(w[31:16]));
      s = longint'(smem[(base - k) & 255]);
      acc += s * c;
    end
    acc = (acc <<< (64 - ACW)) >>> (64 - ACW);
    acc = acc >>> sh;
`ifdef FIR_LANE_SAT_EN
    if (acc > 32767) return 16'sh7fff;
    if (acc < -32768) return 16'sh8000;
`endif
    return acc[15:0];
  endfunction

  always @(negedge clk1) begin
    if (rst) last_out = '0;
    else if (fir_done) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++; $error("FAIL done_unexpected observed=%0d expected=none", pcm_out);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        tests += 2;
        assert (pcm_out === mon_e.val) else begin
          fails++; $error("FAIL pcm_out observed=%0d expected=%0d", pcm_out, mon_e.val);
        end
        assert (cyc === mon_e.cyc) else begin
          fails++; $error("FAIL done_cycle observed=%0d expected=%0d", cyc, mon_e.cyc);
        end
        last_out = mon_e.val;
      end
    end else begin
      tests++;
      assert (pcm_out === last_out) else begin
        fails++; $error("FAIL hold observed=%0d expected=%0d", pcm_out, last_out);
      end
    end
  end

  task automatic wr(input int a, input int v);
    @(negedge clk1);
    pcm_in_wr = 1'b1; pcm_in_address = 8'(a); pcm_in = 16'(v);
    smem[a & 255] = 16'(v);
    @(posedge clk1); #1;
    pcm_in_wr = 1'b0;
  endtask

  task automatic start(input int base, input int len, input int sh,
                       input bit do_wr, input int v, input bit accept);
    exp_t e;
    @(negedge clk1);
    pcm_in_address = 8'(base); tap_len = 12'(len); pcm_out_shift = 4'(sh); fir_start = 1'b1;
    if (do_wr) begin
      pcm_in_wr = 1'b1; pcm_in = 16'(v); smem[base & 255] = 16'(v);
    end
    if (accept) begin
      e.val = model(base, len, sh);
      e.cyc = cyc + 1 + len + 4;
      sb.push_back(e);
    end
    @(negedge clk1);
    fir_start = 1'b0; pcm_in_wr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk1); #2; n++;
    end
    tests++;
    assert (sb.size() == 0) else begin
      fails++; $error("FAIL drain_timeout observed=%0d pending expected=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic set_coefs(input logic [31:0] w, input int nwords);
    for (int i = 0; i < 128; i++) coef_mem[i] = (i < nwords) ? w : 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) smem[i] = '0;
    set_coefs(32'h0, 0);
    repeat (3) @(negedge clk1);
    tests += 3;
    assert (pcm_out === 16'sd0) else begin fails++; $error("FAIL rst_pcm_out observed=%0d expected=0", pcm_out); end
    assert (fir_done === 1'b0) else begin fails++; $error("FAIL rst_fir_done observed=%0d expected=0", fir_done); end
    assert (param_addr === 7'd0) else begin fails++; $error("FAIL rst_param_addr observed=%0d expected=0", param_addr); end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) wr(i, 0);

    // Ramp 0..15, coefs 0x2000, shift 13; also watch param_addr stepping.
    set_coefs(32'h2000_2000, 8);
    for (int i = 0; i < 15; i++) wr(i, i);
    start(15, 8, 13, 1'b1, 15, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk1);
      tests++;
      assert (param_addr === 7'(k)) else begin
        fails++; $error("FAIL param_addr_step observed=%0d expected=%0d", param_addr, k);
      end
    end
    wait_drain(40);

    // Single unit tap: output tracks newest sample for tap_len 9..19.
    set_coefs(32'h0000_2000, 1);
    for (int len = 9; len <= 19; len++) begin
      start(40 + len * 3, len, 13, 1'b1, int'($urandom_range(0, 65535)), 1'b1);
      wait_drain(60);
    end

    // Full-scale accumulation.
    set_coefs(32'h7fff_7fff, 8);
    for (int i = 100; i < 115; i++) wr(i, 32767);
    start(115, 8, 0, 1'b1, 32767, 1'b1);
    wait_drain(40);

    // Window wrapping below address 0.
    set_coefs(32'h0001_0001, 3);
    wr(253, 7); wr(254, 5); wr(255, 4); wr(0, 3); wr(1, 2);
    start(2, 3, 0, 1'b1, 1, 1'b1);
    wait_drain(40);

    // Zero taps.
    start(9, 0, 0, 1'b0, 0, 1'b1);
    wait_drain(20);

    // Restart while busy is ignored.
    set_coefs(32'h0100_0200, 16);
    start(30, 8, 4, 1'b0, 0, 1'b1);
    start(60, 5, 0, 1'b0, 0, 1'b0);
    wait_drain(40);
    repeat (15) @(negedge clk1);

    // Reset mid-computation aborts it silently.
    start(70, 10, 2, 1'b0, 0, 1'b1);
    @(negedge clk1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk1);
    rst = 1'b0;
    tests += 2;
    assert (pcm_out === 16'sd0) else begin fails++; $error("FAIL rst_mid_pcm_out observed=%0d expected=0", pcm_out); end
    assert (param_addr === 7'd0) else begin fails++; $error("FAIL rst_mid_param_addr observed=%0d expected=0", param_addr); end
    repeat (20) @(negedge clk1);
    start(70, 10, 2, 1'b0, 0, 1'b1);
    wait_drain(40);

    // Random coefficients, samples and shifts.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) coef_mem[i] = $urandom;
      for (int i = 0; i < 40; i++) wr(150 + i, int'($urandom_range(0, 65535)));
      start(189, int'($urandom_range(1, 16)), int'($urandom_range(0, 15)), 1'b0, 0, 1'b1);
      wait_drain(60);
    end

    repeat (20) @(negedge clk1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
